// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS receive word aligner.
// Imported by the shift window and the aligner top.
package lvds_rx_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } rx_state_t;

   localparam logic [9:0] DEFAULT_SYNC_WORD = 10'h2C7;

   // Width of a counter running 0..word_w/2-1, never narrower than one bit.
   function automatic int phase_width(input int word_w);
      return (word_w / 2 <= 2) ? 1 : $clog2(word_w / 2);
   endfunction

endpackage

// File: rtl/lvds_rx_shift_window.sv
// Two-bit-per-cycle deserialiser fed by the DDR pad samples.
// Presents the even and odd word windows of the value being shifted in this cycle.
module lvds_rx_shift_window
   import lvds_rx_pkg::*;
#(
   parameter int WORD_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              din0,
   input  logic              din1,
   output logic [WORD_W-1:0] win0,
   output logic [WORD_W-1:0] win1
);

   logic [2*WORD_W-1:0] sr;
   logic [2*WORD_W-1:0] sr_next;

   // din0 arrived first, so it lands above din1 and the oldest bit ends up as MSB.
   assign sr_next = {sr[2*WORD_W-3:0], din0, din1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (en) begin
         sr <= sr_next;
      end
   end

   assign win0 = sr_next[WORD_W-1:0];
   assign win1 = sr_next[WORD_W:1];

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// Finds word alignment from a repeated training word, confirms it on word boundaries,
// then emits one aligned word per WORD_W/2 enabled cycles.
module lvds_rx_word_aligner
   import lvds_rx_pkg::*;
#(
   parameter int                WORD_W     = 10,
   parameter logic [WORD_W-1:0] SYNC_WORD  = WORD_W'(DEFAULT_SYNC_WORD),
   parameter int                LOCK_COUNT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              din0,
   input  logic              din1,
   input  logic              align_req,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   output logic              locked,
   output logic              bit_off
);

   localparam int            PW          = phase_width(WORD_W);
   localparam logic [PW-1:0] PHASE_LAST  = PW'(WORD_W / 2 - 1);
   localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_COUNT);

   rx_state_t         state;
   rx_state_t         state_next;
   logic [PW-1:0]     phase;
   logic [PW-1:0]     phase_inc;
   logic [3:0]        match_cnt;
   logic [WORD_W-1:0] win0;
   logic [WORD_W-1:0] win1;
   logic [WORD_W-1:0] sel_win;
   logic              win0_hit;
   logic              win1_hit;
   logic              sel_hit;
   logic              boundary;
   logic              lock_reached;
   logic              word_load;

   lvds_rx_shift_window #(
      .WORD_W (WORD_W)
   ) u_shift_window (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .din0  (din0),
      .din1  (din1),
      .win0  (win0),
      .win1  (win1)
   );

   assign win0_hit     = (win0 == SYNC_WORD);
   assign win1_hit     = (win1 == SYNC_WORD);
   assign sel_win      = bit_off ? win1 : win0;
   assign sel_hit      = (sel_win == SYNC_WORD);
   assign boundary     = en && (phase == PHASE_LAST);
   assign phase_inc    = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
   assign lock_reached = ((match_cnt + 4'd1) == LOCK_TARGET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   // align_req overrides everything; otherwise only enabled cycles can move the FSM.
   always_comb begin
      state_next = state;
      if (align_req) begin
         state_next = HUNT;
      end else if (en) begin
         case (state)
            HUNT: begin
               if (win0_hit || win1_hit) begin
                  state_next = VERIFY;
               end
            end
            VERIFY: begin
               if (boundary) begin
                  if (!sel_hit) begin
                     state_next = HUNT;
                  end else if (lock_reached) begin
                     state_next = LOCKED;
                  end
               end
            end
            LOCKED: begin
               state_next = LOCKED;
            end
            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   always_comb begin
      locked    = (state == LOCKED);
      word_load = (state == LOCKED) && boundary && !align_req;
   end

   // A hunt hit restarts the phase so the next boundary falls one whole word later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= '0;
         match_cnt <= '0;
         bit_off   <= 1'b0;
      end else if (align_req) begin
         match_cnt <= '0;
         if (en) begin
            phase <= phase_inc;
         end
      end else if (en) begin
         phase <= phase_inc;
         case (state)
            HUNT: begin
               if (win0_hit || win1_hit) begin
                  bit_off   <= !win0_hit;
                  phase     <= '0;
                  match_cnt <= '0;
               end
            end
            VERIFY: begin
               if (boundary) begin
                  match_cnt <= sel_hit ? match_cnt + 4'd1 : 4'd0;
               end
            end
            default: begin
               match_cnt <= match_cnt;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_data  <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= word_load;
         if (word_load) begin
            word_data <= sel_win;
         end
      end
   end

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Directed plus randomised bench for the LVDS word aligner, checked against a
// bit-stream reference model and per-test word scoreboards.
module tb_lvds_rx_word_aligner;

   localparam int             W     = 10;
   localparam logic [W-1:0]   SYNC  = 10'h2C7;
   localparam int             LOCKN = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         din0 = 1'b0;
   logic         din1 = 1'b0;
   logic         align_req = 1'b0;
   logic [W-1:0] word_data;
   logic         word_valid;
   logic         locked;
   logic         bit_off;

   int errors = 0;
   int checks = 0;
   int cycle = 0;

   bit           tx[$];
   bit           hist[$];
   logic [W-1:0] got[$];
   logic [W-1:0] expq[$];
   int           vtimes[$];
   bit           sawLocked;

   int           mState;
   int           mPhase;
   int           mCnt;
   logic         mOff;
   logic         mValid;
   logic         mLocked;
   logic [W-1:0] mData;

   lvds_rx_word_aligner #(
      .WORD_W     (W),
      .SYNC_WORD  (SYNC),
      .LOCK_COUNT (LOCKN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din0       (din0),
      .din1       (din1),
      .align_req  (align_req),
      .word_data  (word_data),
      .word_valid (word_valid),
      .locked     (locked),
      .bit_off    (bit_off)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkCount(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Window ending 'lag' bits before the newest received bit, oldest bit as MSB.
   function automatic logic [W-1:0] modelWin(input int lag);
      logic [W-1:0] w;
      int n;
      n = hist.size();
      for (int i = 0; i < W; i++) begin
         w[W-1-i] = hist[n-W-lag+i];
      end
      return w;
   endfunction

   function automatic void modelReset();
      hist.delete();
      for (int i = 0; i < 2*W; i++) hist.push_back(1'b0);
      mState  = 0;
      mPhase  = 0;
      mCnt    = 0;
      mOff    = 1'b0;
      mValid  = 1'b0;
      mLocked = 1'b0;
      mData   = '0;
   endfunction

   function automatic void modelEdge(input bit d0, input bit d1, input bit e, input bit a);
      bit           bnd;
      logic [W-1:0] w0;
      logic [W-1:0] w1;
      logic [W-1:0] ws;
      mValid = 1'b0;
      if (e) begin
         hist.push_back(d0);
         hist.push_back(d1);
         while (hist.size() > 4*W) void'(hist.pop_front());
      end
      w0  = modelWin(0);
      w1  = modelWin(1);
      ws  = mOff ? w1 : w0;
      bnd = (mPhase == W/2 - 1);
      if (a) begin
         mState  = 0;
         mCnt    = 0;
         mLocked = 1'b0;
         if (e) mPhase = (mPhase + 1) % (W/2);
      end else if (e) begin
         mPhase = (mPhase + 1) % (W/2);
         if (mState == 0) begin
            if (w0 == SYNC || w1 == SYNC) begin
               mOff   = (w0 != SYNC);
               mPhase = 0;
               mCnt   = 0;
               mState = 1;
            end
         end else if (mState == 1) begin
            if (bnd) begin
               if (ws == SYNC) begin
                  mCnt++;
                  if (mCnt == LOCKN) begin
                     mState  = 2;
                     mLocked = 1'b1;
                  end
               end else begin
                  mState = 0;
                  mCnt   = 0;
               end
            end
         end else if (bnd) begin
            mData  = ws;
            mValid = 1'b1;
         end
      end
   endfunction

   task automatic applyStimulus(input bit d0, input bit d1, input bit e, input bit a);
      din0      = d0;
      din1      = d1;
      en        = e;
      align_req = a;
      @(posedge clk);
      cycle++;
      modelEdge(d0, d1, e, a);
      #1;
      checkOutput("word_valid", W'(word_valid), W'(mValid));
      checkOutput("word_data", word_data, mData);
      checkOutput("locked", W'(locked), W'(mLocked));
      checkOutput("bit_off", W'(bit_off), W'(mOff));
      if (word_valid) begin
         got.push_back(word_data);
         vtimes.push_back(cycle);
      end
      if (locked) sawLocked = 1'b1;
   endtask

   task automatic pushWord(input logic [W-1:0] w);
      for (int i = W-1; i >= 0; i--) tx.push_back(w[i]);
   endtask

   // Sends queued bits in pairs; optional 3-cycle en gap, align pulse, or random gaps/aligns.
   task automatic flushTx(input int gapAt, input int alignAt, input bit rnd);
      bit b0;
      bit b1;
      int k;
      k = 0;
      while (tx.size() >= 2) begin
         b0 = tx.pop_front();
         b1 = tx.pop_front();
         if (k == gapAt) repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         if (rnd) begin
            while ($urandom_range(0, 4) == 0)
               applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end
         applyStimulus(b0, b1, 1'b1, (k == alignAt) || (rnd && $urandom_range(0, 99) == 0));
         k++;
      end
      en = 1'b0;
   endtask

   task automatic checkGot(input string tag);
      checkCount({tag, "_count"}, got.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         if (i < got.size()) checkOutput(tag, got[i], expq[i]);
      end
   endtask

   initial begin
      logic [W-1:0] r;

      // Reset values
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_word_data", word_data, '0);
      checkOutput("rst_word_valid", W'(word_valid), '0);
      checkOutput("rst_locked", W'(locked), '0);
      checkOutput("rst_bit_off", W'(bit_off), '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Even lock
      $display("[TB] even lock");
      got.delete(); expq.delete();
      pushWord('0); pushWord('0);
      repeat (6) pushWord(SYNC);
      expq.push_back(SYNC);
      pushWord(10'h155); expq.push_back(10'h155);
      pushWord(10'h0AA); expq.push_back(10'h0AA);
      repeat (2) begin
         r = W'($urandom);
         pushWord(r);
         expq.push_back(r);
      end
      flushTx(-1, -1, 1'b0);
      checkOutput("even_locked", W'(locked), W'(1));
      checkOutput("even_bit_off", W'(bit_off), '0);
      checkGot("even_words");

      // Enable gap inside the middle word
      $display("[TB] enable gaps");
      got.delete(); expq.delete(); vtimes.delete();
      repeat (3) begin
         r = W'($urandom);
         pushWord(r);
         expq.push_back(r);
      end
      flushTx(7, -1, 1'b0);
      checkGot("gap_words");
      checkCount("gap_vtimes", vtimes.size(), 3);
      if (vtimes.size() == 3) begin
         checkCount("gap_spacing_stretched", vtimes[1] - vtimes[0], 8);
         checkCount("gap_spacing_normal", vtimes[2] - vtimes[1], 5);
      end

      // align_req on a boundary while locked
      $display("[TB] realign");
      got.delete();
      pushWord(W'($urandom));
      flushTx(-1, 4, 1'b0);
      checkOutput("realign_no_valid", W'(word_valid), '0);
      checkOutput("realign_unlocked", W'(locked), '0);
      checkCount("realign_no_words", got.size(), 0);
      got.delete(); expq.delete();
      repeat (6) pushWord(SYNC);
      expq.push_back(SYNC);
      pushWord(10'h155); expq.push_back(10'h155);
      flushTx(-1, -1, 1'b0);
      checkOutput("relock_locked", W'(locked), W'(1));
      checkGot("relock_words");

      // Verify failure then relock
      $display("[TB] verify fail");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      sawLocked = 1'b0;
      pushWord('0); pushWord(SYNC); pushWord(SYNC); pushWord(10'h2C6); pushWord('0);
      flushTx(-1, -1, 1'b0);
      checkCount("verify_fail_no_lock", int'(sawLocked), 0);
      repeat (6) pushWord(SYNC);
      pushWord('0);
      flushTx(-1, -1, 1'b0);
      checkOutput("verify_relock", W'(locked), W'(1));
      checkOutput("verify_relock_off", W'(bit_off), '0);

      // Asynchronous reset mid-word while locked
      $display("[TB] async reset");
      repeat (3) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_word_data", word_data, '0);
      checkOutput("async_word_valid", W'(word_valid), '0);
      checkOutput("async_locked", W'(locked), '0);
      checkOutput("async_bit_off", W'(bit_off), '0);
      modelReset();
      tx.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("post_reset_unlocked", W'(locked), '0);

      // Odd lock: same stream delayed by one bit
      $display("[TB] odd lock");
      got.delete(); expq.delete();
      tx.push_back(1'b0);
      pushWord('0);
      repeat (6) pushWord(SYNC);
      expq.push_back(SYNC);
      pushWord(10'h155); expq.push_back(10'h155);
      pushWord(10'h0AA); expq.push_back(10'h0AA);
      pushWord('0);
      flushTx(-1, -1, 1'b0);
      checkOutput("odd_locked", W'(locked), W'(1));
      checkOutput("odd_bit_off", W'(bit_off), W'(1));
      checkGot("odd_words");

      // Randomised traffic with training bursts, gaps and realign pulses
      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         pushWord(($urandom_range(0, 1) == 1) ? SYNC : W'($urandom));
      end
      flushTx(-1, -1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
